// File: rtl/sorter_block_loader.sv
// sorter_block_loader
//   Upstream feeder for the compare-and-swap sorting network. It collects a
//   serial valid/ready element stream into one N-lane block and hands that
//   block downstream over a valid/ready interface. A block that closes early
//   (in_last_i before N elements) has its remaining lanes filled with the
//   largest value of the element type, so an ascending network sorts the
//   pads into the top lanes.
//
// Ports
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   sign_i       0 = unsigned, 1 = signed; taken from the first element only
//   in_valid_i   input element valid
//   in_ready_o   loader can accept an element (high in FILL)
//   in_data_i    input element
//   in_last_i    element closes the current block
//   out_valid_o  block available (high in HOLD)
//   out_ready_i  downstream accepts the block
//   out_data_o   lane i = bits [i*DATAWIDTH +: DATAWIDTH]
//   out_sign_o   sign mode of the block
//   out_count_o  number of real (non-pad) elements, 1..N
module sorter_block_loader #(
    parameter int DATAWIDTH = 8,
    parameter int N         = 8,
    parameter int CW        = $clog2(N) + 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   sign_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATAWIDTH-1:0]   in_data_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [N*DATAWIDTH-1:0] out_data_o,
    output logic                   out_sign_o,
    output logic [CW-1:0]          out_count_o
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N*DATAWIDTH-1:0] data_d;
    logic                   sign_d;
    logic [CW-1:0]          count_d;

    logic                   accept;
    logic                   close;
    logic                   block_sign;
    logic [DATAWIDTH-1:0]   pad;

    // Handshake outputs depend on registered state only.
    assign in_ready_o  = (state_q == FILL);
    assign out_valid_o = (state_q == HOLD);

    assign accept = in_valid_i && (state_q == FILL);
    assign close  = accept && (in_last_i || (idx_q == IW'(N - 1)));

    // On the first element the latched sign is not yet written, so the pad
    // must use the incoming sign directly in that case.
    assign block_sign = (idx_q == '0) ? sign_i : out_sign_o;
    assign pad        = {~block_sign, {(DATAWIDTH - 1){1'b1}}};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = out_data_o;
        sign_d  = out_sign_o;
        count_d = out_count_o;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (idx_q == '0) begin
                        sign_d = sign_i;
                    end
                    for (int unsigned i = 0; i < N; i++) begin
                        if (IW'(i) == idx_q) begin
                            data_d[i*DATAWIDTH +: DATAWIDTH] = in_data_i;
                        end else if (close && (IW'(i) > idx_q)) begin
                            data_d[i*DATAWIDTH +: DATAWIDTH] = pad;
                        end
                    end
                    if (close) begin
                        count_d = {1'b0, idx_q} + CW'(1);
                        idx_d   = '0;
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx_q       <= '0;
            out_data_o  <= '0;
            out_sign_o  <= 1'b0;
            out_count_o <= '0;
        end else begin
            idx_q       <= idx_d;
            out_data_o  <= data_d;
            out_sign_o  <= sign_d;
            out_count_o <= count_d;
        end
    end

endmodule

// File: tb/tb_sorter_block_loader.sv
// tb_sorter_block_loader
//   Self-checking bench for sorter_block_loader (DATAWIDTH=8, N=8).
//   Each test pushes the block it expects onto a scoreboard queue as it
//   drives the elements; a monitor pops and compares on every output
//   handshake. Tests also check handshake timing and hold behaviour inline.
module tb_sorter_block_loader;

    localparam int DW = 8;
    localparam int NN = 8;
    localparam int CWT = 4;

    typedef struct {
        logic [NN*DW-1:0] data;
        logic             sign;
        logic [CWT-1:0]   count;
    } blk_t;

    logic             clk;
    logic             rstn;
    logic             sign;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [NN*DW-1:0] out_data;
    logic             out_sign;
    logic [CWT-1:0]   out_count;

    blk_t exp_q[$];
    int   vectors;
    int   miscompares;

    sorter_block_loader #(
        .DATAWIDTH(DW),
        .N(NN)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .sign_i(sign),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_data_i(in_data),
        .in_last_i(in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o(out_data),
        .out_sign_o(out_sign),
        .out_count_o(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_block: got data=%h sign=%0d count=%0d, none expected",
                         out_data, out_sign, out_count);
            end else begin
                blk_t e;
                e = exp_q.pop_front();
                if (out_data !== e.data) begin
                    miscompares++;
                    $display("FAIL block_data: got %h expected %h", out_data, e.data);
                end
                vectors++;
                if (out_sign !== e.sign) begin
                    miscompares++;
                    $display("FAIL block_sign: got %0d expected %0d", out_sign, e.sign);
                end
                vectors++;
                if (out_count !== e.count) begin
                    miscompares++;
                    $display("FAIL block_count: got %0d expected %0d", out_count, e.count);
                end
            end
        end
    end

    task automatic expect_block(input logic [NN*DW-1:0] d, input logic s, input logic [CWT-1:0] c);
        blk_t b;
        b.data  = d;
        b.sign  = s;
        b.count = c;
        exp_q.push_back(b);
    endtask

    // Present one element (called at posedge+1) and return at posedge+1 after
    // the edge on which it was accepted; in_valid stays high on return.
    task automatic push(input logic [DW-1:0] d, input logic s, input logic l);
        int unsigned guard;
        logic        rdy;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        sign     = s;
        in_last  = l;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic idle_input();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        sign      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_handshake: got valid=%0d ready=%0d expected valid=0 ready=1",
                     out_valid, in_ready);
        end
        vectors++;
        if (out_data !== '0 || out_sign !== 1'b0 || out_count !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h sign=%0d count=%0d expected all zero",
                     out_data, out_sign, out_count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        expect_block(64'h01020304_05060708, 1'b0, 4'd8);
        for (int i = 8; i >= 1; i--) begin
            push(8'(i), 1'b0, 1'b0);
        end
        idle_input();
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_after_last: got valid=%0d ready=%0d expected valid=1 ready=0",
                     out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_one_cycle: got valid=%0d ready=%0d expected valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_short_signed();
        expect_block(64'h7F7F7F7F_7F7F0580, 1'b1, 4'd2);
        push(8'h80, 1'b1, 1'b0);
        push(8'h05, 1'b0, 1'b1);
        idle_input();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_unsigned();
        expect_block(64'hFFFFFFFF_FFFFFF10, 1'b0, 4'd1);
        push(8'h10, 1'b0, 1'b1);
        idle_input();
        repeat (2) @(posedge clk);
        #1;
        // Signed single element: pad must use the sign of this same element.
        expect_block(64'h7F7F7F7F_7F7F7F81, 1'b1, 4'd1);
        push(8'h81, 1'b1, 1'b1);
        idle_input();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        expect_block(64'h88776655_44332211, 1'b0, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            push(8'(i * 17), 1'b0, 1'b0);
        end
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b0;
        sign     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_handshake: cycle %0d got valid=%0d ready=%0d expected 1/0",
                         c, out_valid, in_ready);
            end
            vectors++;
            if (out_data !== 64'h88776655_44332211 || out_count !== 4'd8) begin
                miscompares++;
                $display("FAIL hold_stable: cycle %0d got data=%h count=%0d expected 8877665544332211/8",
                         c, out_data, out_count);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        expect_block(64'hFFFFFFFF_FFFF01AA, 1'b0, 4'd2);
        push(8'hAA, 1'b0, 1'b0);
        push(8'h01, 1'b0, 1'b1);
        idle_input();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_sign_latch();
        out_ready = 1'b1;
        // Last on the 8th element: one full block, no pads.
        expect_block(64'h28272625_24232221, 1'b0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h21 + i), (i == 3), (i == 7));
        end
        idle_input();
        repeat (2) @(posedge clk);
        #1;
        expect_block(64'h7F7F7F7F_93929190, 1'b1, 4'd4);
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h90 + i), (i == 0), (i == 3));
        end
        idle_input();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(8'(8'hE0 + i), 1'b1, 1'b0);
        end
        idle_input();
        rstn = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 ||
            out_sign !== 1'b0 || out_count !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got valid=%0d ready=%0d data=%h sign=%0d count=%0d expected 0/1/0/0/0",
                     out_valid, in_ready, out_data, out_sign, out_count);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        expect_block(64'h38373635_34333231, 1'b0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h31 + i), 1'b0, 1'b0);
        end
        idle_input();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int unsigned guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d blocks outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_back_to_back();
        test_short_signed();
        test_single_unsigned();
        test_hold();
        test_sign_latch();
        test_mid_reset();
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sorter_block_loader.md
Name: sorter_block_loader

Overview:
- Upstream feeder for the compare-and-swap sorting network.
- Accepts a serial valid/ready element stream and assembles N elements into one parallel block with a per-block sign-mode bit.
- Hands the block to the network lanes over a valid/ready interface.
- A short final block (in_last_i before N elements) is padded with the type's maximum value, so an ascending network pushes the pads to the top lanes.

Parameters:
- DATAWIDTH, 8, element width in bits.
- N, 8, elements per block; power of two, N >= 2.
- CW, $clog2(N)+1, width of the count field (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- sign_i  in  1  0 = unsigned, 1 = signed; sampled only on the first element of a block.
- in_valid_i  in  1  input element valid.
- in_ready_o  out  1  loader can accept an element.
- in_data_i  in  DATAWIDTH  input element.
- in_last_i  in  1  element closes the current block.
- out_valid_o  out  1  block available.
- out_ready_i  in  1  downstream accepts the block.
- out_data_o  out  N*DATAWIDTH  lane i = bits [i*DATAWIDTH +: DATAWIDTH].
- out_sign_o  out  1  sign mode of the block.
- out_count_o  out  CW  number of real (non-pad) elements, 1..N.

Behaviour:
- Reset (async, rstn_i=0):
  - state=FILL, idx=0.
  - out_valid_o=0, out_data_o=0, out_sign_o=0, out_count_o=0, in_ready_o=1 after reset release.
- States:
  - FILL: in_ready_o=1, out_valid_o=0.
  - HOLD: in_ready_o=0, out_valid_o=1.
  - in_ready_o and out_valid_o are pure functions of registered state, with no combinational path from out_ready_i or in_valid_i.
- FILL, on an accepted element (in_valid_i & in_ready_o):
  - Slot idx <= in_data_i.
  - If idx==0, out_sign_o <= sign_i; sign_i is ignored on later elements of the block.
- FILL, block close: when the accepted element has idx==N-1 or in_last_i=1:
  - Slots idx+1..N-1 <= PAD in the same edge.
  - out_count_o <= idx+1, idx <= 0, state <= HOLD.
  - out_valid_o rises the next cycle.
  - Otherwise idx <= idx+1.
- Simultaneous idx==N-1 and in_last_i: a single full block, count=N, no pads.
- PAD value:
  - sign mode 0: all ones.
  - sign mode 1: 0 followed by all ones (0x7F for 8 bits).
  - The sign used is the block's latched sign, including when the closing element is also the first (idx==0).
- HOLD: out_data_o, out_sign_o and out_count_o stay stable while out_valid_o=1 and out_ready_i=0.
- HOLD exit: out_valid_o & out_ready_i -> state <= FILL.
  - in_ready_o rises the next cycle, so a back-to-back stream gives one idle cycle per block.
  - Block data may remain on out_data_o after exit; it is don't-care while out_valid_o=0.
- Latency: the last element accepted at edge t gives out_valid_o=1 after edge t.
- in_valid_i while in_ready_o=0: no effect; the upstream must hold its data.
- Mid-operation reset: a partial block is discarded and all outputs return to reset values immediately (async).

Test Plan:
- DATAWIDTH=8, N=8, sign=0, stream 8..1 back-to-back, out_ready=1 -> one block, lanes 0..7 = 8,7,6,5,4,3,2,1, count=8, sign=0, out_valid high 1 cycle; in_ready low exactly 1 cycle.
- sign=1, elements 0x80,0x05 with last on the second -> lanes = 0x80,0x05,0x7F×6, count=2, out_sign=1.
- sign=0, single element 0x10 with last -> lanes = 0x10,0xFF×7, count=1.
- Full block held with out_ready=0 for 5 cycles while in_valid=1 with new data -> out_data/count stable, in_ready=0, no element consumed; out_ready=1 -> exit, then the new data is accepted as lane 0 of the next block.
- sign_i toggled to 1 on element 3 of an unsigned block -> out_sign=0; sign_i=1 on the first element of the next block -> out_sign=1.
- rstn_i pulsed low after 3 elements accepted -> out_valid=0, idx=0; the next 8 elements form a clean block, count=8.
